multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock, the only clock.
REQ-002 rst_n  input  1  reset; synchronous, active-low.
REQ-003 op  input  6  instruction opcode, IR[31:26].
REQ-004 funct  input  6  R-type function field, IR[5:0].
REQ-005 zero  input  1  ALU zero flag, same-cycle combinational from ALU result.
REQ-006 alu_ctrl  output  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-007 alu_src_a  output  1  ALU A select: 0 PC, 1 register A.
REQ-008 alu_src_b  output  2  ALU B select: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
REQ-009 iord  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-010 mem_write, ir_write, reg_write  output  1 each  write strobes.
REQ-011 reg_dst  output  1  destination: 0 rt, 1 rd.
REQ-012 mem_to_reg  output  1  write-back data: 0 ALUOut, 1 memory data.
REQ-013 pc_src  output  2  next PC: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-014 pc_en  output  1  PC register load enable.
REQ-015 state  output  4  current state code, for debug and verification.

Function
REQ-016 Moore FSM; one state register updated on rising clk; all outputs except pc_en decode from state only.
REQ-017 State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11; codes 12-15 unused.
REQ-018 Transitions: FETCH->DECODE; DECODE by op: 100011 lw or 101011 sw ->MEMADR, 000000 ->EXECUTE, 000100 ->BRANCH, 001000 ->ADDIEXEC, 000010 ->JUMP, any other ->FETCH (executes as NOP).
REQ-019 MEMADR->MEMREAD if op=100011, else MEMWRITE; MEMREAD->MEMWB; EXECUTE->ALUWB; ADDIEXEC->ADDIWB; MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH, JUMP ->FETCH.
REQ-020 Unused state code reached: next state FETCH, all strobes 0.
REQ-021 Per-state asserted outputs; every output not listed is 0:
 - FETCH: alu_src_b=01, alu ADD, ir_write=1, pc_write=1, pc_src=00.
 - DECODE: alu_src_b=11, alu ADD.
 - MEMADR, ADDIEXEC: alu_src_a=1, alu_src_b=10, alu ADD.
 - MEMREAD: iord=1. MEMWRITE: iord=1, mem_write=1.
 - MEMWB: mem_to_reg=1, reg_write=1. ADDIWB: reg_write=1.
 - EXECUTE: alu_src_a=1, alu_src_b=00, alu_ctrl from funct.
 - ALUWB: reg_dst=1, reg_write=1.
 - BRANCH: alu_src_a=1, alu_src_b=00, alu SUB, pc_src=01, branch=1.
 - JUMP: pc_src=10, pc_write=1.
REQ-022 Funct decode (EXECUTE only): 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct->010.
REQ-023 pc_en = pc_write OR (branch AND zero), combinational; zero sampled in BRANCH cycle.
REQ-024 Instruction latencies, FETCH to FETCH: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
REQ-025 op and funct are held stable by IR from DECODE onward; FSM does not register them.

Reset
REQ-026 rst_n=0 at a rising clk edge: state<=FETCH (0) regardless of current state, including mid-instruction.
REQ-027 While rst_n=0: all strobes (ir_write, mem_write, reg_write, pc_en) forced 0; other outputs equal FETCH decode.
REQ-028 First rising edge with rst_n=1 executes FETCH with strobes enabled.

Verification
REQ-029 Reset, then op=100011 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-030 op=000000, funct=101010 -> state 6 shows alu_ctrl=111; state 7 shows reg_dst=1, reg_write=1; back to 0.
REQ-031 op=000100, zero=1 in state 8 -> pc_en=1, pc_src=01; repeat with zero=0 -> pc_en=0; zero=1 outside BRANCH/FETCH/JUMP -> pc_en=0.
REQ-032 op=101011 -> states 0,1,2,5,0; mem_write=1 and iord=1 only in state 5; reg_write never 1.
REQ-033 rst_n=0 asserted in state 3 (lw MEMREAD) -> next state 0, all strobes 0 while low; op=111111 after reset -> 0,1,0 with no strobes outside FETCH.
REQ-034 op=000000, funct=000000 -> alu_ctrl=010 in state 6; op=000010 -> state 11 with pc_src=10, pc_en=1.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller is the master: it reads the IR fields and the ALU zero
// flag, and drives every datapath select and write strobe.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alu_ctrl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] pc_src;
  logic       pc_en;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output alu_ctrl, alu_src_a, alu_src_b, iord, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, pc_src, pc_en, state
  );

  modport slave (
    output op, funct, zero,
    input  alu_ctrl, alu_src_a, alu_src_b, iord, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, pc_src, pc_en, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller (Moore FSM).
//
//   state         | meaning
//   FETCH    (0)  | read instruction, PC <= PC + 4
//   DECODE   (1)  | read registers, precompute branch target
//   MEMADR   (2)  | lw/sw effective address
//   MEMREAD  (3)  | lw data memory read
//   MEMWB    (4)  | lw write-back into rt
//   MEMWRITE (5)  | sw data memory write
//   EXECUTE  (6)  | R-type ALU operation
//   ALUWB    (7)  | R-type write-back into rd
//   BRANCH   (8)  | beq compare, PC <= target when equal
//   ADDIEXEC (9)  | addi ALU operation
//   ADDIWB   (10) | addi write-back into rt
//   JUMP     (11) | PC <= jump target
//
// Control outputs are registered alongside the state, decoded from the
// next state, so they always match the state register. The reset gating
// of strobes and the zero-dependent part of pc_en stay combinational.
module multicycle_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_out;

  function automatic state_t next_of(input state_t s, input logic [5:0] op);
    next_of = S_FETCH;
    case (s)
      S_FETCH:    next_of = S_DECODE;
      S_DECODE: begin
        case (op)
          6'b100011, 6'b101011: next_of = S_MEMADR;
          6'b000000:            next_of = S_EXECUTE;
          6'b000100:            next_of = S_BRANCH;
          6'b001000:            next_of = S_ADDIEXEC;
          6'b000010:            next_of = S_JUMP;
          default:              next_of = S_FETCH;
        endcase
      end
      S_MEMADR:   next_of = (op == 6'b100011) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_of = S_MEMWB;
      S_EXECUTE:  next_of = S_ALUWB;
      S_ADDIEXEC: next_of = S_ADDIWB;
      default:    next_of = S_FETCH;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] funct);
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_alu = ALU_ADD;
    endcase
  endfunction

  // Unlisted and unused state codes leave every output at 0.
  function automatic ctrl_t decode(input state_t s, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = 2'b01; c.alu_ctrl = ALU_ADD;
        c.ir_write = 1'b1;   c.pc_write = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11; c.alu_ctrl = ALU_ADD;
      end
      S_MEMADR, S_ADDIEXEC: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = ALU_ADD;
      end
      S_MEMREAD:  c.iord = 1'b1;
      S_MEMWRITE: begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_ADDIWB:   c.reg_write = 1'b1;
      S_EXECUTE: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.alu_ctrl = funct_alu(funct);
      end
      S_ALUWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.alu_ctrl = ALU_SUB;
        c.pc_src = 2'b01;   c.branch = 1'b1;
      end
      S_JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // State register and registered control decode of the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode(S_FETCH, 6'b000000);
    end else begin
      state_q <= next_of(state_q, bus.op);
      ctrl_q  <= decode(next_of(state_q, bus.op), bus.funct);
    end
  end

  // While reset is low, present the FETCH decode with every strobe held off.
  always_comb begin
    ctrl_out = ctrl_q;
    if (!rst_n) begin
      ctrl_out           = decode(S_FETCH, 6'b000000);
      ctrl_out.ir_write  = 1'b0;
      ctrl_out.mem_write = 1'b0;
      ctrl_out.reg_write = 1'b0;
      ctrl_out.pc_write  = 1'b0;
      ctrl_out.branch    = 1'b0;
    end
  end

  assign bus.alu_ctrl   = ctrl_out.alu_ctrl;
  assign bus.alu_src_a  = ctrl_out.alu_src_a;
  assign bus.alu_src_b  = ctrl_out.alu_src_b;
  assign bus.iord       = ctrl_out.iord;
  assign bus.mem_write  = ctrl_out.mem_write;
  assign bus.ir_write   = ctrl_out.ir_write;
  assign bus.reg_write  = ctrl_out.reg_write;
  assign bus.reg_dst    = ctrl_out.reg_dst;
  assign bus.mem_to_reg = ctrl_out.mem_to_reg;
  assign bus.pc_src     = ctrl_out.pc_src;
  // zero comes straight from the ALU in the BRANCH cycle.
  assign bus.pc_en      = ctrl_out.pc_write | (ctrl_out.branch & bus.zero);
  assign bus.state      = state_q;

endmodule
